// File: rtl/sfifo_param.sv
// Parametrised single-clock FIFO with programmable thresholds, optional
// first-word-fall-through read mode and sticky overflow/underflow flags.
module sfifo_param #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned AF_LEVEL = 14,
  parameter int unsigned AE_LEVEL = 2,
  parameter int unsigned FWFT     = 0,
  localparam int unsigned ABITS   = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             write_n,
  input  logic             read_n,
  input  logic             clr_err,
  output logic [WIDTH-1:0] data_out,
  output logic             valid,
  output logic             full,
  output logic             empty,
  output logic             half,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [ABITS:0]   counter,
  output logic             overflow,
  output logic             underflow
);

  localparam int unsigned CW = ABITS + 1;

  logic [ABITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [ABITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             rd_acc, wr_acc;

  // Status flags decode straight from the registered occupancy
  always_comb begin
    full         = (cnt_q == CW'(DEPTH));
    empty        = (cnt_q == '0);
    half         = (cnt_q >= CW'(DEPTH / 2));
    almost_full  = (cnt_q >= CW'(AF_LEVEL));
    almost_empty = (cnt_q <= CW'(AE_LEVEL));
    counter      = cnt_q;
    overflow     = ovf_q;
    underflow    = udf_q;
  end

  // A write into a full FIFO is only legal when a read frees a slot that cycle
  always_comb begin
    rd_acc = ~read_n & ~empty;
    wr_acc = ~write_n & (~full | rd_acc);
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + ABITS'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + ABITS'(1);
    unique case ({wr_acc, rd_acc})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    // A fresh error in the clear cycle keeps the flag set
    ovf_d = (ovf_q & ~clr_err) | (~write_n & ~wr_acc);
    udf_d = (udf_q & ~clr_err) | (~read_n & ~rd_acc);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage array is intentionally not reset
  always_ff @(posedge clock) begin
    if (wr_acc) mem_q[wr_ptr_q] <= data_in;
  end

  if (FWFT != 0) begin : g_fwft
    // Head word shown directly; forced to zero while empty so reset reads zero
    always_comb begin
      data_out = empty ? '0 : mem_q[rd_ptr_q];
      valid    = ~empty;
    end
  end else begin : g_reg
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             vld_q, vld_d;

    always_comb begin
      dout_d = dout_q;
      vld_d  = rd_acc;
      if (rd_acc) dout_d = mem_q[rd_ptr_q];
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        dout_q <= '0;
        vld_q  <= 1'b0;
      end else begin
        dout_q <= dout_d;
        vld_q  <= vld_d;
      end
    end

    always_comb begin
      data_out = dout_q;
      valid    = vld_q;
    end
  end

endmodule

// File: tb/tb_sfifo_param.sv
// Directed bench for sfifo_param: registered-read instance checked through a
// read-data scoreboard, plus a small FWFT instance checked inline.
module tb_sfifo_param;

  logic       clock;
  logic       reset;
  logic [7:0] a_din;
  logic       a_wn, a_rn, a_clr;
  logic [7:0] a_dout;
  logic       a_valid, a_full, a_empty, a_half, a_af, a_ae, a_ovf, a_udf;
  logic [4:0] a_cnt;

  logic       b_rst;
  logic [7:0] b_din;
  logic       b_wn, b_rn, b_clr;
  logic [7:0] b_dout;
  logic       b_valid, b_full, b_empty, b_half, b_af, b_ae, b_ovf, b_udf;
  logic [2:0] b_cnt;

  int checks   = 0;
  int failures = 0;
  logic [7:0] sbq[$];

  sfifo_param #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(0)) u_a (
    .clock(clock), .reset(reset), .data_in(a_din), .write_n(a_wn), .read_n(a_rn),
    .clr_err(a_clr), .data_out(a_dout), .valid(a_valid), .full(a_full),
    .empty(a_empty), .half(a_half), .almost_full(a_af), .almost_empty(a_ae),
    .counter(a_cnt), .overflow(a_ovf), .underflow(a_udf)
  );

  sfifo_param #(.WIDTH(8), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(1)) u_b (
    .clock(clock), .reset(b_rst), .data_in(b_din), .write_n(b_wn), .read_n(b_rn),
    .clr_err(b_clr), .data_out(b_dout), .valid(b_valid), .full(b_full),
    .empty(b_empty), .half(b_half), .almost_full(b_af), .almost_empty(b_ae),
    .counter(b_cnt), .overflow(b_ovf), .underflow(b_udf)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every valid read word must match the oldest expectation
  always @(negedge clock) begin
    if (!reset && a_valid) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected_valid actual=0x%0h required=none at %0t", a_dout, $time);
      end else begin
        chk("sb_read_data", a_dout, sbq.pop_front());
      end
    end
  end

  task automatic cyc_a(input logic wn, input logic rn, input logic clr, input logic [7:0] d);
    a_wn = wn; a_rn = rn; a_clr = clr; a_din = d;
    @(posedge clock); #1;
    a_wn = 1'b1; a_rn = 1'b1; a_clr = 1'b0;
  endtask

  task automatic cyc_b(input logic wn, input logic rn, input logic [7:0] d);
    b_wn = wn; b_rn = rn; b_din = d;
    @(posedge clock); #1;
    b_wn = 1'b1; b_rn = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; b_rst = 1'b1;
    a_din = '0; a_wn = 1'b1; a_rn = 1'b1; a_clr = 1'b0;
    b_din = '0; b_wn = 1'b1; b_rn = 1'b1; b_clr = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0; b_rst = 1'b0;

    chk("rst_counter", a_cnt, 0);
    chk("rst_empty",   a_empty, 1);
    chk("rst_ae",      a_ae, 1);
    chk("rst_full",    a_full, 0);
    chk("rst_half",    a_half, 0);
    chk("rst_af",      a_af, 0);
    chk("rst_valid",   a_valid, 0);
    chk("rst_dout",    a_dout, 0);
    chk("rst_ovf",     a_ovf, 0);
    chk("rst_udf",     a_udf, 0);

    // Fill with 0x01..0x10 and track the threshold flags
    for (int i = 1; i <= 16; i++) begin
      cyc_a(1'b0, 1'b1, 1'b0, 8'(i));
      chk("fill_counter", a_cnt, i);
      chk("fill_empty",   a_empty, 0);
      chk("fill_half",    a_half, int'(i >= 8));
      chk("fill_af",      a_af, int'(i >= 14));
      chk("fill_full",    a_full, int'(i == 16));
      chk("fill_ae",      a_ae, int'(i <= 2));
    end

    cyc_a(1'b0, 1'b1, 1'b0, 8'hAA);
    chk("ovf_set",     a_ovf, 1);
    chk("ovf_counter", a_cnt, 16);
    chk("ovf_no_udf",  a_udf, 0);

    // Drain: oldest-first, 0xAA must not appear
    for (int i = 1; i <= 16; i++) begin
      sbq.push_back(8'(i));
      cyc_a(1'b1, 1'b0, 1'b0, 8'h00);
      chk("drain_counter", a_cnt, 16 - i);
      chk("drain_ae",      a_ae, int'((16 - i) <= 2));
      chk("drain_empty",   a_empty, int'(i == 16));
    end

    cyc_a(1'b1, 1'b1, 1'b0, 8'h00);
    chk("idle_valid", a_valid, 0);

    cyc_a(1'b1, 1'b0, 1'b0, 8'h00);
    chk("udf_set",       a_udf, 1);
    chk("udf_dout_hold", a_dout, 8'h10);
    chk("udf_valid",     a_valid, 0);
    chk("udf_counter",   a_cnt, 0);
    chk("udf_ovf_kept",  a_ovf, 1);

    cyc_a(1'b1, 1'b1, 1'b1, 8'h00);
    chk("clr_ovf", a_ovf, 0);
    chk("clr_udf", a_udf, 0);

    cyc_a(1'b1, 1'b0, 1'b1, 8'h00);
    chk("clr_vs_new_udf", a_udf, 1);
    cyc_a(1'b1, 1'b1, 1'b1, 8'h00);
    chk("clr_again_udf", a_udf, 0);

    for (int i = 1; i <= 16; i++) cyc_a(1'b0, 1'b1, 1'b0, 8'(i));
    chk("refill_full", a_full, 1);

    // Full with simultaneous read+write for 20 cycles
    for (int i = 0; i < 20; i++) begin
      sbq.push_back((i < 16) ? 8'(i + 1) : 8'(8'h20 + i - 16));
      cyc_a(1'b0, 1'b0, 1'b0, 8'(8'h20 + i));
      chk("rw_counter", a_cnt, 16);
      chk("rw_no_ovf",  a_ovf, 0);
      chk("rw_no_udf",  a_udf, 0);
    end

    for (int i = 0; i < 16; i++) begin
      sbq.push_back(8'(8'h24 + i));
      cyc_a(1'b1, 1'b0, 1'b0, 8'h00);
    end
    chk("rw_drained_empty", a_empty, 1);

    cyc_a(1'b0, 1'b0, 1'b0, 8'h55);
    chk("er_counter", a_cnt, 1);
    chk("er_udf",     a_udf, 1);
    chk("er_ovf",     a_ovf, 0);
    chk("er_valid",   a_valid, 0);

    sbq.push_back(8'h55);
    cyc_a(1'b1, 1'b0, 1'b0, 8'h00);
    chk("er_read_counter", a_cnt, 0);
    cyc_a(1'b1, 1'b1, 1'b0, 8'h00);
    cyc_a(1'b1, 1'b1, 1'b0, 8'h00);
    chk("sb_drained", sbq.size(), 0);

    // FWFT instance, depth 4
    chk("b_rst_valid", b_valid, 0);
    chk("b_rst_dout",  b_dout, 0);
    chk("b_rst_empty", b_empty, 1);

    cyc_b(1'b0, 1'b1, 8'h7E);
    chk("b_fwft_valid",   b_valid, 1);
    chk("b_fwft_dout",    b_dout, 8'h7E);
    chk("b_fwft_counter", b_cnt, 1);

    cyc_b(1'b0, 1'b1, 8'h11);
    cyc_b(1'b0, 1'b1, 8'h22);
    chk("b_mid_counter", b_cnt, 3);
    chk("b_mid_af",      b_af, 1);
    chk("b_mid_dout",    b_dout, 8'h7E);

    // Asynchronous reset between clock edges
    b_rst = 1'b1;
    #1;
    chk("b_arst_counter", b_cnt, 0);
    chk("b_arst_empty",   b_empty, 1);
    chk("b_arst_valid",   b_valid, 0);
    chk("b_arst_dout",    b_dout, 0);
    chk("b_arst_af",      b_af, 0);
    chk("b_arst_ae",      b_ae, 1);
    #1 b_rst = 1'b0;

    cyc_b(1'b0, 1'b1, 8'h99);
    chk("b_post_dout",  b_dout, 8'h99);
    chk("b_post_valid", b_valid, 1);
    chk("b_post_cnt",   b_cnt, 1);

    cyc_b(1'b0, 1'b1, 8'hA1);
    cyc_b(1'b0, 1'b1, 8'hA2);
    cyc_b(1'b0, 1'b1, 8'hA3);
    chk("b_full", b_full, 1);

    cyc_b(1'b0, 1'b0, 8'hA4);
    chk("b_rw_dout", b_dout, 8'hA1);
    chk("b_rw_cnt",  b_cnt, 4);
    chk("b_rw_ovf",  b_ovf, 0);

    cyc_b(1'b0, 1'b1, 8'hEE);
    chk("b_ovf", b_ovf, 1);
    chk("b_ovf_dout", b_dout, 8'hA1);

    for (int i = 0; i < 4; i++) cyc_b(1'b1, 1'b0, 8'h00);
    chk("b_drain_empty", b_empty, 1);
    chk("b_drain_valid", b_valid, 0);
    chk("b_drain_udf",   b_udf, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sfifo_param.md
Name: sfifo_param

Overview:
- Parametrised synchronous single-clock FIFO; next generation of the team's 16x8 sfifo.
- Adds configurable width and depth, programmable almost-full/almost-empty thresholds, optional first-word-fall-through (FWFT) read mode, read-data valid, and sticky overflow/underflow error flags.
- Used as the general buffering element between producer/consumer blocks in one clock domain.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- DEPTH, 16, number of entries; power of two, >=4.
- AF_LEVEL, 14, almost_full asserts when counter >= AF_LEVEL (1..DEPTH).
- AE_LEVEL, 2, almost_empty asserts when counter <= AE_LEVEL (0..DEPTH-1).
- FWFT, 0, 0 = registered read (1-cycle latency); 1 = first-word-fall-through.
- Derived localparam ABITS = log2(DEPTH).

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- data_in  in  WIDTH  write data.
- write_n  in  1  write request, active low.
- read_n  in  1  read request, active low.
- clr_err  in  1  synchronous clear of overflow/underflow, active high.
- data_out  out  WIDTH  read data.
- valid  out  1  data_out holds valid read data.
- full  out  1  counter == DEPTH.
- empty  out  1  counter == 0.
- half  out  1  counter >= DEPTH/2.
- almost_full  out  1  counter >= AF_LEVEL.
- almost_empty  out  1  counter <= AE_LEVEL.
- counter  out  ABITS+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a write was rejected.
- underflow  out  1  sticky: a read was rejected.

Behaviour:
- Reset (async, immediate): rd/wr pointers=0, counter=0, data_out=0, valid=0, overflow=0, underflow=0; hence empty=1, almost_empty=1, full=0, half=0, almost_full=0. Memory array is not reset. Reset mid-operation discards all contents; first accepted write after release lands at address 0.
- Read accept: rd_acc = ~read_n & ~empty.
- Write accept: wr_acc = ~write_n & (~full | rd_acc). Write on full is allowed only when paired with an accepted read.
- Write on empty with simultaneous read: write accepted, read rejected (underflow set), counter 0->1.
- Counter: +1 on wr_acc only; -1 on rd_acc only; unchanged on both or neither. Never exceeds DEPTH, never wraps below 0.
- Pointers are ABITS wide, +1 on their accept, natural wrap DEPTH-1 -> 0. Memory write at wr_ptr on wr_acc.
- Flags are combinational from registered counter, no added delay; valid in the same cycle the counter updates.
- FWFT=0: on rd_acc, data_out <= mem[rd_ptr] at that edge (1-cycle latency); valid=1 the following cycle only; data_out holds its value when no read.
- FWFT=1: data_out = mem[rd_ptr] combinationally; valid = ~empty; rd_acc consumes the shown word, and the next word appears after that edge. A word written into an empty FIFO is visible the cycle after the write edge.
- Errors: overflow <= 1 on ~write_n & ~wr_acc; underflow <= 1 on ~read_n & ~rd_acc. Rejected operations change no pointer, counter or memory. clr_err clears both flags; a new error in the same cycle as clr_err wins (flag stays 1).
- No internal write-read bypass other than the rules above. A full FIFO with simultaneous read+write returns the oldest word.

Test Plan:
- Reset, then write 0x01..0x10 (16 writes) -> counter 0..16; half at 8; almost_full at 14; full at 16; empty=0 after the first write.
- Continue from full: write 0xAA alone -> overflow=1, counter=16, next 16 reads return 0x01..0x10 (FWFT=0: each data_out one cycle after its read with valid=1), then empty=1, almost_empty from counter=2.
- Read on empty -> underflow=1, data_out unchanged, valid=0. Pulse clr_err -> both flags 0. Repeat with an illegal read in the clr_err cycle -> underflow stays 1.
- Fill to 16, then 20 cycles of simultaneous read+write (data 0x20..0x33) -> counter stays 16; no overflow; reads return 0x01..0x10 then 0x20..0x23; pointers wrap cleanly.
- Empty FIFO, simultaneous read+write 0x55 -> counter=1, underflow=1; next read returns 0x55.
- FWFT=1, DEPTH=4: write 0x7E -> next cycle valid=1, data_out=0x7E before any read. Assert reset mid-fill (counter=3) -> all outputs return to reset values immediately; the next write/read returns the new data.
